// File: rtl/andor_pipe.sv
// Three-stage elastic valid/ready datapath computing y = (a OP1 b) OP2 c bitwise,
// with per-transaction operator codes and a wrapping count of delivered results.
module andor_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       op1,
    input  logic [1:0]       op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    function automatic logic f_op(input logic [1:0] i_op, input logic i_x, input logic i_z);
        case (i_op)
            OP_AND:  f_op = i_x & i_z;
            OP_OR:   f_op = i_x | i_z;
            OP_XOR:  f_op = i_x ^ i_z;
            default: f_op = ~(i_x ^ i_z);
        endcase
    endfunction

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_r;
    logic [WIDTH-1:0] r_s1_c;
    logic [1:0]       r_s1_op2;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_s2_r;
    logic             r_s3_v;
    logic [WIDTH-1:0] r_s3_y;
    logic [CNT_W-1:0] r_done_cnt;

    logic             w_ready1;
    logic             w_ready2;
    logic             w_ready3;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_s1_d;
    logic [WIDTH-1:0] w_s2_d;

    // Ready ripples combinationally from the consumer back to the producer.
    assign w_ready3   = !r_s3_v || out_ready;
    assign w_ready2   = !r_s2_v || w_ready3;
    assign w_ready1   = !r_s1_v || w_ready2;
    assign w_out_xfer = r_s3_v && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_s1_d[gi] = f_op(op1, a[gi], b[gi]);
            assign w_s2_d[gi] = f_op(r_s1_op2, r_s1_r[gi], r_s1_c[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s1_v   <= 1'b0;
            r_s1_r   <= '0;
            r_s1_c   <= '0;
            r_s1_op2 <= '0;
        end else if (w_ready1) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_r   <= w_s1_d;
                r_s1_c   <= c;
                r_s1_op2 <= op2;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s2_v <= 1'b0;
            r_s2_r <= '0;
        end else if (w_ready2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_r <= w_s2_d;
            end
        end
    end

    // The output register only loads when the consumer has taken (or never had) its value,
    // so y is frozen for the whole of a stall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s3_v <= 1'b0;
            r_s3_y <= '0;
        end else if (w_ready3) begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_y <= r_s2_r;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_done_cnt <= '0;
        end else if (w_out_xfer) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_ready1;
    assign out_valid = r_s3_v;
    assign y         = r_s3_y;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_andor_pipe.sv
// Directed, table-driven bench for andor_pipe: a vector table with hand-computed results
// feeds an expected-result queue that an output monitor drains in order.
module tb_andor_pipe;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [1:0] op1;
        logic [1:0] op2;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [28];

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic [15:0] done_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  y2;
    logic [1:0]  done_cnt2;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_y;
    logic [7:0]  held_y;
    logic        was_stalled;

    andor_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .done_cnt(done_cnt)
    );

    // Narrow-counter instance sharing all stimulus, used for the wrap check.
    andor_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .op1(op1), .op2(op2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .done_cnt(done_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                        input logic [1:0] o1, input logic [1:0] o2, input logic [7:0] vy);
        vecs[i].a = va; vecs[i].b = vb; vecs[i].c = vc;
        vecs[i].op1 = o1; vecs[i].op2 = o2; vecs[i].y = vy;
    endtask

    task automatic drive(input int i);
        a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
        op1 = vecs[i].op1; op2 = vecs[i].op2;
    endtask

    // mode 0: out_ready high, 1: random out_ready, 2: out_ready every third cycle.
    // While a vector waits for in_ready its op codes are scrambled every cycle.
    task automatic run_vecs(input int lo, input int hi, input int mode, output int cycles);
        int idx;
        int cyc;
        idx = lo;
        cyc = 0;
        while ((idx <= hi || exp_q.size() != 0) && cyc < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc % 3 == 2);
            endcase
            #1;
            if (idx <= hi) begin
                in_valid = 1'b1;
                drive(idx);
                if (in_ready) begin
                    exp_q.push_back(vecs[idx].y);
                    idx++;
                end else begin
                    op1 = 2'(cyc);
                    op2 = 2'(cyc + 1);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("drain_empty", exp_q.size(), 0);
        cycles = cyc;
    endtask

    // Output monitor: checks every output transfer against the queue and y stability on stalls.
    initial begin
        was_stalled = 1'b0;
        held_y      = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                was_stalled = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    if (was_stalled) chk("y_hold", y, held_y);
                    held_y      = y;
                    was_stalled = 1'b1;
                end else begin
                    was_stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: got y=0x%0h, required no output", y);
                    end else begin
                        exp_y = exp_q.pop_front();
                        chk("y", y, exp_y);
                        chk("y_dut2", y2, exp_y);
                    end
                end
            end
        end
    end

    initial begin
        int          cyc;
        int          acc;
        int          v;
        int          t;
        logic [7:0]  sweep_y [16];
        int          wrap_exp [5];

        sweep_y  = '{8'h05, 8'hFF, 8'hFA, 8'h05,
                     8'hAF, 8'hFF, 8'h50, 8'hAF,
                     8'hAA, 8'hFF, 8'h55, 8'hAA,
                     8'h55, 8'hFF, 8'hAA, 8'h55};
        wrap_exp = '{1, 2, 3, 0, 1};

        setv(0, 8'hF0, 8'h3C, 8'h01, OP_AND, OP_OR, 8'h31);
        for (int i = 0; i < 16; i++)
            setv(1 + i, 8'hA5, 8'h0F, 8'hFF, 2'(i / 4), 2'(i % 4), sweep_y[i]);
        setv(17, 8'h12, 8'h34, 8'h56, OP_AND,  OP_XOR,  8'h46);
        setv(18, 8'hFF, 8'h00, 8'h0F, OP_OR,   OP_AND,  8'h0F);
        setv(19, 8'h3C, 8'h0F, 8'hAA, OP_XOR,  OP_OR,   8'hBB);
        setv(20, 8'h81, 8'h18, 8'h00, OP_XNOR, OP_XOR,  8'h66);
        setv(21, 8'h55, 8'hAA, 8'hF0, OP_AND,  OP_XNOR, 8'h0F);
        setv(22, 8'hC3, 8'h5A, 8'h3C, OP_AND,  OP_XOR,  8'h7E);
        setv(23, 8'hC3, 8'h5A, 8'h3C, OP_OR,   OP_AND,  8'h18);
        setv(24, 8'hC3, 8'h5A, 8'h3C, OP_XOR,  OP_XNOR, 8'h5A);
        setv(25, 8'hC3, 8'h5A, 8'h3C, OP_XNOR, OP_AND,  8'h24);
        setv(26, 8'hC3, 8'h5A, 8'h3C, OP_XOR,  OP_XOR,  8'hA5);
        setv(27, 8'hC3, 8'h5A, 8'h3C, OP_OR,   OP_OR,   8'hFF);

        // Reset state
        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; op1 = '0; op2 = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_done_cnt2", done_cnt2, 0);
        nrst = 1'b1;

        // Single transaction latency
        in_valid = 1'b1;
        drive(0);
        #1;
        chk("single_in_ready", in_ready, 1);
        exp_q.push_back(vecs[0].y);
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", out_valid, 0);
        tick();
        chk("lat_cycle2_valid", out_valid, 0);
        tick();
        chk("lat_cycle3_valid", out_valid, 1);
        chk("lat_cycle3_y", y, 8'h31);
        tick();
        chk("single_done_cnt", done_cnt, 1);
        chk("single_after_valid", out_valid, 0);

        // Operator sweep, back to back
        run_vecs(1, 16, 0, cyc);
        chk("sweep_cycles", cyc, 19);
        chk("sweep_done_cnt", done_cnt, 17);

        // Backpressure: five offers against a stalled consumer
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            v = 17 + acc;
            in_valid = 1'b1;
            drive(v);
            #1;
            if (in_ready) begin
                exp_q.push_back(vecs[v].y);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_y", y, vecs[17].y);
        run_vecs(17 + acc, 21, 1, cyc);
        chk("bp_done_cnt", done_cnt, 22);

        // Op codes changing every cycle during stalls
        run_vecs(22, 27, 2, cyc);
        chk("midop_done_cnt", done_cnt, 28);

        // Reset with three transactions in flight
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            drive(i);
            exp_q.push_back(vecs[i].y);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_y", y, vecs[1].y);
        nrst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_y", y, 0);
        chk("arst_done_cnt", done_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_in_ready2", in_ready2, 1);
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        tick();
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale_valid", out_valid, 0);
        end

        // Counter wrap on the two-bit instance
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            drive(1 + k);
            exp_q.push_back(vecs[1 + k].y);
            tick();
            in_valid = 1'b0;
            t = 0;
            while (exp_q.size() != 0 && t < 10) begin
                tick();
                t++;
            end
            chk("wrap_delivered", exp_q.size(), 0);
            chk("cnt_wrap", done_cnt2, wrap_exp[k]);
            chk("cnt_main", done_cnt, k + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
